div_unit: RTL and testbench

//  Multi-cycle radix-2 restoring divider serving the EX stage (responder side of EX div request).
//  EX raises start_i with operands and holds stall until ready_o; result feeds HI/LO via EX hi_o/lo_o.

---
 rtl/div_unit.sv | 170 +++++++++++++++++
 tb/tb_div_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for the EX stage.
// Handles signed (DIV) and unsigned (DIVU) divides. EX holds start_i high
// until ready_o is seen. annul_i aborts the divide on a pipeline flush.
//
// Ports:
//   clk           system clock; all state changes on the rising edge
//   rst           asynchronous, active-low reset
//   signed_div_i  1 = signed divide, 0 = unsigned divide
//   opdata1_i     dividend (sampled only on the FREE->ON transition)
//   opdata2_i     divisor  (sampled only on the FREE->ON transition)
//   start_i       request, held high by EX until ready_o is seen
//   annul_i       abort the current divide and return to FREE
//   result_o      {remainder, quotient}, which maps to {HI, LO}
//   ready_o       result valid (registered)
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*DATA_W:0]      work_q, work_d;
  logic [DATA_W-1:0]      abs_b_q, abs_b_d;
  logic                   sign_a_q, sign_a_d;
  logic                   sign_b_q, sign_b_d;
  logic                   signed_q, signed_d;
  logic [2*DATA_W-1:0]    result_q, result_d;
  logic                   ready_q, ready_d;

  // Operand magnitudes. Only a signed divide with the MSB set is negated.
  logic [DATA_W-1:0] abs_a, abs_b;
  assign abs_a = (signed_div_i && opdata1_i[DATA_W-1]) ? ({DATA_W{1'b0}} - opdata1_i) : opdata1_i;
  assign abs_b = (signed_div_i && opdata2_i[DATA_W-1]) ? ({DATA_W{1'b0}} - opdata2_i) : opdata2_i;

  // Trial subtraction of the divisor from the upper partial remainder.
  // Bit DATA_W is the borrow, so a set bit means the subtraction fails.
  logic [DATA_W:0] diff;
  assign diff = work_q[2*DATA_W:DATA_W] - {1'b0, abs_b_q};

  // Final fix-up. The quotient sign is the XOR of the operand signs.
  // The remainder sign follows the dividend.
  logic [DATA_W-1:0] quot, rem, quot_fix, rem_fix;
  assign quot     = work_q[DATA_W-1:0];
  assign rem      = work_q[2*DATA_W:DATA_W+1];
  assign quot_fix = (signed_q && (sign_a_q ^ sign_b_q)) ? ({DATA_W{1'b0}} - quot) : quot;
  assign rem_fix  = (signed_q && sign_a_q) ? ({DATA_W{1'b0}} - rem) : rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      work_q   <= '0;
      abs_b_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      signed_q <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      abs_b_q  <= abs_b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      signed_q <= signed_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    abs_b_d  = abs_b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    signed_d = signed_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      S_FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          cnt_d = '0;
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d  = S_ON;
            signed_d = signed_div_i;
            sign_a_d = signed_div_i & opdata1_i[DATA_W-1];
            sign_b_d = signed_div_i & opdata2_i[DATA_W-1];
            abs_b_d  = abs_b;
            work_d   = {{DATA_W{1'b0}}, abs_a, 1'b0};
          end
        end
      end
      S_BYZERO: begin
        // The divide-by-zero response is reported two edges after the request.
        // cnt provides the extra wait cycle.
        if (annul_i) begin
          state_d = S_FREE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end else begin
          state_d  = S_END;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d  = S_FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q != CNT_W'(DATA_W)) begin
          if (diff[DATA_W])
            work_d = {work_q[2*DATA_W-1:0], 1'b0};
          else
            work_d = {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d  = S_END;
          cnt_d    = '0;
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
        end
      end
      S_END: begin
        // A new divide needs start_i to drop first.
        // This stops a held request from restarting the divider.
        if (annul_i || !start_i) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_FREE;
      end
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1, opdata2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  div_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div),
    .opdata1_i(opdata1), .opdata2_i(opdata2),
    .start_i(start), .annul_i(annul),
    .result_o(result), .ready_o(ready)
  );

  // Reference: {remainder, quotient} from plain integer division (truncating).
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = longint'(a) / longint'(b);
      r = longint'(a) % longint'(b);
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Raise a request and wait (bounded) for ready.
  // n = edges after the sampling edge. Operands are scrambled once sampled.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int n);
    signed_div = s; opdata1 = a; opdata2 = b; start = 1'b1; annul = 1'b0;
    @(posedge clk); #1;
    signed_div = 1'($urandom); opdata1 = $urandom; opdata2 = $urandom;
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    res = result;
  endtask

  task automatic drop_start();
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; opdata1 = '0; opdata2 = '0;
    #1;
    tests++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      fails++;
      $display("FAIL reset_outputs got ready=%b result=%h exp 0/0", ready, result);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      fails++;
      $display("FAIL idle_after_reset got ready=%b result=%h exp 0/0", ready, result);
    end
  endtask

  task automatic test_unsigned();
    logic [63:0] res, exp;
    logic [31:0] a, b;
    int n;
    run_div(1'b0, 32'd100, 32'd7, res, n);
    tests++;
    if (n !== 33) begin fails++; $display("FAIL udiv_latency got %0d exp 33", n); end
    tests++;
    if (res !== {32'd2, 32'd14}) begin fails++; $display("FAIL udiv_100_7 got %h exp %h", res, {32'd2, 32'd14}); end
    drop_start();
    tests++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      fails++;
      $display("FAIL udiv_back_to_free got ready=%b result=%h exp 0/0", ready, result);
    end
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = (i < 10) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (b == 32'd0) b = 32'd1;
      exp = model(1'b0, a, b);
      run_div(1'b0, a, b, res, n);
      tests++;
      if (res !== exp || n !== 33) begin
        fails++;
        $display("FAIL udiv_random %h/%h got %h lat %0d exp %h lat 33", a, b, res, n, exp);
      end
      drop_start();
    end
  endtask

  task automatic test_signed();
    logic [63:0] res, exp;
    logic [31:0] a, b;
    int n;
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, res, n);
    tests++;
    if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD} || n !== 33) begin
      fails++; $display("FAIL sdiv_m7_2 got %h lat %0d exp ffffffff_fffffffd lat 33", res, n);
    end
    drop_start();
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, res, n);
    tests++;
    if (res !== {32'd1, 32'hFFFF_FFFD}) begin
      fails++; $display("FAIL sdiv_7_m2 got %h exp 00000001_fffffffd", res);
    end
    drop_start();
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = (i < 10) ? ((i % 2) ? -32'($urandom_range(1, 500)) : 32'($urandom_range(1, 500))) : $urandom;
      if (b == 32'd0) b = 32'd3;
      exp = model(1'b1, a, b);
      run_div(1'b1, a, b, res, n);
      tests++;
      if (res !== exp || n !== 33) begin
        fails++;
        $display("FAIL sdiv_random %h/%h got %h lat %0d exp %h lat 33", a, b, res, n, exp);
      end
      drop_start();
    end
  endtask

  task automatic test_byzero();
    logic [63:0] res;
    int n;
    run_div(1'b0, 32'h1234, 32'd0, res, n);
    tests++;
    if (n !== 2 || res !== 64'd0) begin
      fails++; $display("FAIL byzero_unsigned got lat %0d res %h exp lat 2 res 0", n, res);
    end
    drop_start();
    run_div(1'b1, 32'h8000_0000, 32'd0, res, n);
    tests++;
    if (n !== 2 || res !== 64'd0) begin
      fails++; $display("FAIL byzero_signed got lat %0d res %h exp lat 2 res 0", n, res);
    end
    drop_start();
  endtask

  task automatic test_annul();
    logic [63:0] res;
    int n, seen;
    signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd7; start = 1'b1; annul = 1'b0;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready) seen++;
      @(posedge clk); #1;
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL annul_no_ready got %0d ready cycles exp 0", seen); end
    run_div(1'b0, 32'd9, 32'd3, res, n);
    tests++;
    if (res !== {32'd0, 32'd3} || n !== 33) begin
      fails++; $display("FAIL annul_restart got %h lat %0d exp 00000000_00000003 lat 33", res, n);
    end
    drop_start();
  endtask

  task automatic test_overflow();
    logic [63:0] res;
    int n;
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, n);
    tests++;
    if (res !== {32'd0, 32'h8000_0000}) begin
      fails++; $display("FAIL sdiv_overflow got %h exp 00000000_80000000", res);
    end
    drop_start();
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, res, n);
    tests++;
    if (res !== {32'd0, 32'hFFFF_FFFF}) begin
      fails++; $display("FAIL udiv_max_by_1 got %h exp 00000000_ffffffff", res);
    end
    drop_start();
  endtask

  task automatic test_rst_mid();
    logic [63:0] res;
    int n, seen;
    signed_div = 1'b0; opdata1 = 32'd5000; opdata2 = 32'd3; start = 1'b1; annul = 1'b0;
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    tests++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      fails++; $display("FAIL rst_mid_on got ready=%b result=%h exp 0/0", ready, result);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    annul = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready) seen++;
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL start_annul_free got %0d ready cycles exp 0", seen); end
    // Still idle: a plain request now shows full latency from its own edge.
    run_div(1'b0, 32'd50, 32'd8, res, n);
    tests++;
    if (res !== {32'd2, 32'd6} || n !== 33) begin
      fails++; $display("FAIL after_start_annul got %h lat %0d exp 00000002_00000006 lat 33", res, n);
    end
    drop_start();
  endtask

  task automatic test_end_hold();
    logic [63:0] res;
    int n, bad;
    run_div(1'b0, 32'd1000, 32'd33, res, n);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ready !== 1'b1 || result !== {32'd10, 32'd30}) bad++;
    end
    tests++;
    if (bad !== 0 || res !== {32'd10, 32'd30}) begin
      fails++; $display("FAIL end_hold got %0d unstable cycles res %h exp 0 and 0000000a_0000001e", bad, res);
    end
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    tests++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      fails++; $display("FAIL annul_in_end got ready=%b result=%h exp 0/0", ready, result);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_byzero();
    test_annul();
    test_overflow();
    test_rst_mid();
    test_end_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
